// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: shared size encodings, FSM state codes and the store lane-merge helper
// for mem_access_unit. Revision 1.0.
`default_nettype none

package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_DATA  = 3'd2;
  localparam logic [2:0] ST_WR       = 3'd3;
  localparam logic [2:0] ST_ERR      = 3'd4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  // Replace only the addressed byte/half lane of old_word; word size replaces everything.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = {24'd0, wdata[7:0]} << {lane, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = {16'd0, wdata[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (old_word & ~mask) | (data & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core-side load/store request/response bus of mem_access_unit.
// Revision 1.0.
`default_nettype none

interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
// load_align: extracts/extends byte or half lanes of a RAM word; with ROTATE_UNALIGNED_EN
// a word access is rotated right by 8*lane (ARMv4 LDR). Revision 1.0.
`default_nettype none

module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
`ifdef ROTATE_UNALIGNED_EN
    case (i_lane)
      2'd0:    w_word = i_word;
      2'd1:    w_word = {i_word[7:0],  i_word[31:8]};
      2'd2:    w_word = {i_word[15:0], i_word[31:16]};
      default: w_word = {i_word[23:0], i_word[31:24]};
    endcase
`else
    w_word = i_word;
`endif
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = w_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end to a single-port word RAM with sub-word RMW stores.
// Optional ROTATE_UNALIGNED_EN allows misaligned word accesses. Revision 1.0.
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_access_unit_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic                  o_ram_oe,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  logic [2:0]            r_state;
  resp_t                 r_resp;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_word;

  logic        w_accept;
  logic        w_reject;
  logic        w_range_err;
  logic        w_half_mis;
  logic        w_word_mis;
  logic [31:0] w_load_data;

  assign bus.req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;

  assign w_range_err = (bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign w_half_mis  = (bus.req_size == SZ_HALF) && bus.req_addr[0];
`ifdef ROTATE_UNALIGNED_EN
  assign w_word_mis  = 1'b0;
`else
  assign w_word_mis  = (bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00);
`endif
  assign w_reject = (bus.req_size == SZ_ILL) || w_range_err || w_half_mis || w_word_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_resp  <= '0;
    end else begin
      r_resp <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_reject)
              r_state <= ST_ERR;
            else if (bus.req_we && (bus.req_size == SZ_WORD))
              r_state <= ST_WR;
            else
              r_state <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: r_state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (r_we) begin
            r_state <= ST_WR;
          end else begin
            r_state      <= ST_IDLE;
            r_resp.valid <= 1'b1;
            r_resp.rdata <= w_load_data;
          end
        end
        ST_WR: begin
          r_state      <= ST_IDLE;
          r_resp.valid <= 1'b1;
        end
        ST_ERR: begin
          r_state      <= ST_IDLE;
          r_resp.valid <= 1'b1;
          r_resp.err   <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Request fields are frozen at accept; r_wr_word later becomes the merged RMW word.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we      <= bus.req_we;
      r_size    <= bus.req_size;
      r_signed  <= bus.req_signed;
      r_addr    <= bus.req_addr[ADDR_WIDTH+1:0];
      r_wr_word <= bus.req_wdata;
    end else if ((r_state == ST_RD_DATA) && r_we) begin
      r_wr_word <= merge_lanes(i_ram_rdata, r_wr_word, r_size, r_addr[1:0]);
    end
  end

  load_align u_load_align (
    .i_word   (i_ram_rdata),
    .i_lane   (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load_data)
  );

  assign o_ram_cs      = !rst && ((r_state == ST_RD_ISSUE) || (r_state == ST_RD_DATA) ||
                                  (r_state == ST_WR));
  assign o_ram_oe      = !rst && ((r_state == ST_RD_ISSUE) || (r_state == ST_RD_DATA));
  assign o_ram_we      = !rst && (r_state == ST_WR);
  assign o_ram_address = r_addr[ADDR_WIDTH+1:2];
  assign o_ram_wdata   = r_wr_word;

  assign bus.resp_valid = r_resp.valid;
  assign bus.resp_err   = r_resp.err;
  assign bus.resp_rdata = r_resp.rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus reset-abort and back-to-back sequences
// against a behavioural model of the single-port word RAM.
`default_nettype none

module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  logic [AW-1:0] ram_address;
  logic          ram_cs, ram_we, ram_oe;
  logic [31:0]   ram_wdata, ram_rdata;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .o_ram_address (ram_address),
    .o_ram_cs      (ram_cs),
    .o_ram_we      (ram_we),
    .o_ram_oe      (ram_oe),
    .o_ram_wdata   (ram_wdata),
    .i_ram_rdata   (ram_rdata)
  );

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_address] <= ram_wdata;
    if (ram_cs && ram_oe && !ram_we) ram_rdata <= mem[ram_address];
  end

  int n_cs = 0, n_we = 0, n_resp = 0;
  always @(negedge clk) begin
    if (ram_cs) n_cs <= n_cs + 1;
    if (ram_we) n_we <= n_we + 1;
    if (bus.resp_valid) n_resp <= n_resp + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          cs;
    int          wen;
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] sz, logic sg, logic [31:0] addr,
                              logic [31:0] wd, logic err, logic [31:0] rd,
                              int lat, int cs, int wen);
    vec_t v;
    v.we = we; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
    v.err = err; v.rd = rd; v.lat = lat; v.cs = cs; v.wen = wen;
    return v;
  endfunction

  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int lat,
                         output int dcs, output int dwe);
    int guard;
    int cs0, we0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = addr; bus.req_wdata = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cs0 = n_cs; we0 = n_we;
    lat = 0; err = 1'b0; rd = '0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (bus.resp_valid) begin
        err = bus.resp_err;
        rd  = bus.resp_rdata;
        break;
      end
    end
    dcs = n_cs - cs0;
    dwe = n_we - we0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t        vecs[$];
  logic        g_err;
  logic [31:0] g_rd;
  int          g_lat, g_dcs, g_dwe, we_snap, resp_snap;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst ready",  {31'd0, bus.req_ready}, 32'd0);
    check("rst rvalid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst rerr",   {31'd0, bus.resp_err}, 32'd0);
    check("rst rdata",  bus.resp_rdata, 32'd0);
    check("rst ctl",    {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready after rst", {31'd0, bus.req_ready}, 32'd1);

    // we sz sg addr wdata | err rdata lat cs we
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h10,  32'h11223344, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h14,  32'h11223344, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h18,  32'h11223344, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h1C,  32'hCAFEF00D, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h20,  32'h55667788, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b1, SZ_BYTE, 1'b0, 32'h13,  32'h000000AA, 1'b0, 32'h0, 3, 3, 1));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        1'b0, 32'hAA223344, 2, 2, 0));
    vecs.push_back(mk(1'b0, SZ_BYTE, 1'b1, 32'h13,  32'h0,        1'b0, 32'hFFFFFFAA, 2, 2, 0));
    vecs.push_back(mk(1'b0, SZ_BYTE, 1'b0, 32'h13,  32'h0,        1'b0, 32'h000000AA, 2, 2, 0));
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b1, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2, 2, 0));
    vecs.push_back(mk(1'b1, SZ_HALF, 1'b0, 32'h16,  32'h00008001, 1'b0, 32'h0, 3, 3, 1));
    vecs.push_back(mk(1'b0, SZ_HALF, 1'b1, 32'h16,  32'h0,        1'b0, 32'hFFFF8001, 2, 2, 0));
    vecs.push_back(mk(1'b0, SZ_HALF, 1'b0, 32'h14,  32'h0,        1'b0, 32'h00003344, 2, 2, 0));
    vecs.push_back(mk(1'b0, SZ_HALF, 1'b0, 32'h11,  32'h0,        1'b1, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1'b0, SZ_ILL,  1'b0, 32'h10,  32'h0,        1'b1, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0,       1'b1, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'h0BADF00D, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'h0,        1'b0, 32'h0BADF00D, 2, 2, 0));
`ifdef ROTATE_UNALIGNED_EN
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h1A,  32'h0,        1'b0, 32'h33441122, 2, 2, 0));
`else
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h1A,  32'h0,        1'b1, 32'h0, 1, 0, 0));
`endif
    vecs.push_back(mk(1'b1, SZ_BYTE, 1'b0, 32'h19,  32'hFFFFFF5A, 1'b0, 32'h0, 3, 3, 1));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h18,  32'h0,        1'b0, 32'h11225A44, 2, 2, 0));
    vecs.push_back(mk(1'b0, SZ_BYTE, 1'b1, 32'h18,  32'h0,        1'b0, 32'h00000044, 2, 2, 0));
    vecs.push_back(mk(1'b1, SZ_HALF, 1'b0, 32'h15,  32'h0000FFFF, 1'b1, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h14,  32'h0,        1'b0, 32'h80013344, 2, 2, 0));
`ifdef ROTATE_UNALIGNED_EN
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h1D,  32'h01020304, 1'b0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h1C,  32'h0,        1'b0, 32'h01020304, 2, 2, 0));
`else
    vecs.push_back(mk(1'b1, SZ_WORD, 1'b0, 32'h1D,  32'h01020304, 1'b1, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1'b0, SZ_WORD, 1'b0, 32'h1C,  32'h0,        1'b0, 32'hCAFEF00D, 2, 2, 0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd,
              g_err, g_rd, g_lat, g_dcs, g_dwe);
      check($sformatf("v%0d err", i),   {31'd0, g_err}, {31'd0, vecs[i].err});
      check($sformatf("v%0d rdata", i), g_rd, vecs[i].rd);
      check($sformatf("v%0d latency", i), g_lat, vecs[i].lat);
      check($sformatf("v%0d cs cycles", i), g_dcs, vecs[i].cs);
      check($sformatf("v%0d we cycles", i), g_dwe, vecs[i].wen);
    end

    // Reset lands while the byte RMW sits in WR: no write, no response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h00000077;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    we_snap = n_we; resp_snap = n_resp;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst in WR ctl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst abort we", n_we - we_snap, 32'd0);
    check("rst abort resp", n_resp - resp_snap, 32'd0);
    check("rst abort mem", mem[8], 32'h55667788);
    run_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, g_err, g_rd, g_lat, g_dcs, g_dwe);
    check("rst abort readback", g_rd, 32'h55667788);

    // Back-to-back: next request held valid through the response cycle.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_WORD; bus.req_signed = 1'b0;
    bus.req_addr = 32'h24; bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_we = 1'b0; bus.req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("b2b store resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd2);
    check("b2b ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("b2b accepted", {31'd0, bus.req_ready}, 32'd0);
    check("b2b no early resp", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("b2b no resp +1", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("b2b load resp", {31'd0, bus.resp_valid}, 32'd1);
    check("b2b load rdata", bus.resp_rdata, 32'h12345678);
    check("b2b mem", mem[9], 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
